demux_32bit_1to2: RTL

Registered 32-bit 1-to-2 stream demultiplexer: steers each accepted input word to output channel 0 or 1 according to a per-word select bit. It is the inverse of the 32-bit 2-to-1 mux datapath (sel=0 ↔ channel 0/in1 side, sel=1 ↔ channel 1/in2 side). Each channel is a one-entry output register with a valid/ready handshake and a saturating transfer counter. It sits between a single producer and two independent consumers.

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_slot.sv | 67 ++++++
 rtl/demux_32bit_1to2.sv | 70 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// ============================================================================
// demux_pkg : shared widths and channel-select encoding for demux_32bit_1to2
// Revision  : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;
    localparam int   DATA_W = 32;
    localparam int   CNT_W  = 16;
    localparam logic CH0    = 1'b0;
    localparam logic CH1    = 1'b1;
endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// demux_slot : one-entry output register with valid/ready and drain counter
// Revision   : 1.0
// ============================================================================
`default_nettype none

module demux_slot
    import demux_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  d,
    output logic          valid,
    input  logic          ready,
    output logic [W-1:0]  q,
    input  logic          clear_cnt,
    output logic [CW-1:0] cnt
);

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q,  data_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          w_drain;

    assign w_drain = valid_q && ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // A load in the drain cycle overwrites the slot, so no bubble appears.
        if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end else if (w_drain) begin
            valid_d = 1'b0;
        end
        if (clear_cnt) begin
            cnt_d = '0;
        end else if (w_drain && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;
    assign cnt   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/demux_32bit_1to2.sv
// ============================================================================
// demux_32bit_1to2 : registered 1-to-2 stream demultiplexer with per-channel
//                    transfer counters
// Revision         : 1.0
// ============================================================================
`default_nettype none

module demux_32bit_1to2 #(
    parameter int WIDTH = demux_pkg::DATA_W,
    parameter int CNT_W = demux_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    input  logic             clear_cnt
);
    import demux_pkg::*;

    logic w_tgt_valid;
    logic w_tgt_ready;
    logic w_accept;
    logic w_load0;
    logic w_load1;

    // Only the addressed slot decides whether the word can be taken.
    assign w_tgt_valid = (in_sel == CH1) ? out1_valid : out0_valid;
    assign w_tgt_ready = (in_sel == CH1) ? out1_ready : out0_ready;
    assign in_ready    = !w_tgt_valid || w_tgt_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_load0     = w_accept && (in_sel == CH0);
    assign w_load1     = w_accept && (in_sel == CH1);

    demux_slot #(.W(WIDTH), .CW(CNT_W)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load0),
        .d         (in_data),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .q         (out0_data),
        .clear_cnt (clear_cnt),
        .cnt       (cnt0)
    );

    demux_slot #(.W(WIDTH), .CW(CNT_W)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load1),
        .d         (in_data),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .q         (out1_data),
        .clear_cnt (clear_cnt),
        .cnt       (cnt1)
    );

endmodule

`default_nettype wire
